// File: rtl/pipe_hazard_if.sv
// Hazard-source inputs and register enable/flush outputs shared between the
// pipeline datapath (master) and the stall/flush sequencer (slave).
interface pipe_hazard_if;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       mem_access;
    logic       branch_taken;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               mem_access, branch_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               mem_access, branch_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, branch flush
// and load-use stall, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_if.slave     hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;
    localparam logic [2:0] WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    logic [0:0] state;
    logic [2:0] wcnt;
    logic       freeze_start;
    logic       frozen;
    logic       load_use;
    logic       branch_flush;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;

    // The release cycle (MEM_WAIT with wcnt==0) ignores mem_access so the access in MEM can retire.
    assign freeze_start = (MEM_LAT > 1) && (state == RUN) && hz.mem_access;
    assign frozen       = freeze_start || ((state == MEM_WAIT) && (wcnt != 3'd0));

    assign load_use = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                      ((hz.id_ex_rt == hz.if_id_rs) ||
                       (hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        branch_flush = 1'b0;
        if (!rst && !frozen) begin
            if (hz.branch_taken) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_en    = mem_wb_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= 3'd0;
        end else if (freeze_start) begin
            state <= MEM_WAIT;
            wcnt  <= WAIT_INIT;
        end else if (state == MEM_WAIT) begin
            if (wcnt != 3'd0) begin
                wcnt <= wcnt - 3'd1;
            end else begin
                state <= RUN;
            end
        end
    end

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branch_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives three pipe_hazard_ctrl configurations with one shared stimulus and
// compares each against a cycle-position reference model.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       ma;
    logic       bt;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    pipe_hazard_if hz0 ();
    pipe_hazard_if hz1 ();
    pipe_hazard_if hz2 ();

    logic [1:0]  sc0, fe0;
    logic [15:0] sc1, fe1, sc2, fe2;

    pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(2))  dut0 (.clk(clk), .rst(rst), .hz(hz0.slave), .stall_cycles(sc0), .flush_events(fe0));
    pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .hz(hz1.slave), .stall_cycles(sc1), .flush_events(fe1));
    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) dut2 (.clk(clk), .rst(rst), .hz(hz2.slave), .stall_cycles(sc2), .flush_events(fe2));

    assign {hz0.id_ex_mem_read, hz0.id_ex_rt, hz0.if_id_rs, hz0.if_id_rt, hz0.if_id_uses_rt, hz0.mem_access, hz0.branch_taken} = {mr, ert, rs, rt, urt, ma, bt};
    assign {hz1.id_ex_mem_read, hz1.id_ex_rt, hz1.if_id_rs, hz1.if_id_rt, hz1.if_id_uses_rt, hz1.mem_access, hz1.branch_taken} = {mr, ert, rs, rt, urt, ma, bt};
    assign {hz2.id_ex_mem_read, hz2.id_ex_rt, hz2.if_id_rs, hz2.if_id_rt, hz2.if_id_uses_rt, hz2.mem_access, hz2.branch_taken} = {mr, ert, rs, rt, urt, ma, bt};

    logic [7:0]  obs    [3];
    logic [15:0] obs_sc [3];
    logic [15:0] obs_fe [3];

    assign obs[0] = {hz0.pc_en, hz0.if_id_en, hz0.id_ex_en, hz0.ex_mem_en, hz0.mem_wb_en, hz0.if_id_flush, hz0.id_ex_flush, hz0.ex_mem_flush};
    assign obs[1] = {hz1.pc_en, hz1.if_id_en, hz1.id_ex_en, hz1.ex_mem_en, hz1.mem_wb_en, hz1.if_id_flush, hz1.id_ex_flush, hz1.ex_mem_flush};
    assign obs[2] = {hz2.pc_en, hz2.if_id_en, hz2.id_ex_en, hz2.ex_mem_en, hz2.mem_wb_en, hz2.if_id_flush, hz2.id_ex_flush, hz2.ex_mem_flush};
    assign obs_sc[0] = {14'd0, sc0};
    assign obs_fe[0] = {14'd0, fe0};
    assign obs_sc[1] = sc1;
    assign obs_fe[1] = fe1;
    assign obs_sc[2] = sc2;
    assign obs_fe[2] = fe2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pos is cycles elapsed since a memory access began (-1 = none in flight).
    int lat  [3] = '{1, 2, 3};
    int cmax [3] = '{3, 65535, 65535};
    int pos  [3] = '{-1, -1, -1};
    int m_sc [3] = '{0, 0, 0};
    int m_fe [3] = '{0, 0, 0};
    bit cnt_known = 1'b0;

    function automatic bit model_frozen(int i);
        if (pos[i] < 0) return ma && (lat[i] > 1);
        return pos[i] <= lat[i] - 2;
    endfunction

    // Bit order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id, id_ex, ex_mem flushes.
    function automatic logic [7:0] model_ctrl(int i);
        bit lu;
        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        if (rst)             return 8'b00000_000;
        if (model_frozen(i)) return 8'b00000_000;
        if (bt)              return 8'b11111_111;
        if (lu)              return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic check_output();
        logic [7:0] exp_ctrl;
        for (int i = 0; i < 3; i++) begin
            exp_ctrl = model_ctrl(i);
            checks++;
            assert (obs[i] === exp_ctrl) else begin
                errors++;
                $error("[TB] FAIL %s ctrl[%0d] observed=%b expected=%b", phase, i, obs[i], exp_ctrl);
            end
            if (cnt_known) begin
                checks += 2;
                assert (obs_sc[i] === 16'(m_sc[i])) else begin
                    errors++;
                    $error("[TB] FAIL %s stall_cycles[%0d] observed=%0d expected=%0d", phase, i, obs_sc[i], m_sc[i]);
                end
                assert (obs_fe[i] === 16'(m_fe[i])) else begin
                    errors++;
                    $error("[TB] FAIL %s flush_events[%0d] observed=%0d expected=%0d", phase, i, obs_fe[i], m_fe[i]);
                end
            end
        end
        // Advance the model to the state the coming clock edge produces.
        for (int i = 0; i < 3; i++) begin
            exp_ctrl = model_ctrl(i);
            if (rst) begin
                pos[i]  = -1;
                m_sc[i] = 0;
                m_fe[i] = 0;
            end else begin
                if (!exp_ctrl[7] && m_sc[i] < cmax[i]) m_sc[i]++;
                if (exp_ctrl == 8'hFF && m_fe[i] < cmax[i]) m_fe[i]++;
                if (pos[i] < 0) begin
                    if (ma && lat[i] > 1) pos[i] = 1;
                end else begin
                    pos[i]++;
                end
                if (pos[i] >= lat[i]) pos[i] = -1;
            end
        end
        if (rst) cnt_known = 1'b1;
    endtask

    task automatic apply_stimulus(input logic r, input logic m_r, input logic [4:0] e_rt,
                                  input logic [4:0] s_rs, input logic [4:0] s_rt,
                                  input logic u_rt, input logic m_a, input logic b_t);
        rst = r; mr = m_r; ert = e_rt; rs = s_rs; rt = s_rt; urt = u_rt; ma = m_a; bt = b_t;
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        phase = "reset";
        apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();

        phase = "mem_freeze";
        repeat (3) apply_stimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        checks++;
        assert (sc2 === 16'd2) else begin
            errors++;
            $error("[TB] FAIL mem_freeze_lat3_stalls observed=%0d expected=2", sc2);
        end

        phase = "reset_mid_wait";
        apply_stimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        checks++;
        assert (obs[2] === 8'b11111_000 && sc2 === 16'd0) else begin
            errors++;
            $error("[TB] FAIL reset_mid_wait_lat3 ctrl=%b stalls=%0d expected ctrl=11111000 stalls=0", obs[2], sc2);
        end

        phase = "load_use";
        apply_stimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
        idle();
        checks++;
        assert (sc0 === 2'd1) else begin
            errors++;
            $error("[TB] FAIL load_use_single_stall observed=%0d expected=1", sc0);
        end

        phase = "no_hazard";
        apply_stimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        phase = "rt_hazard";
        apply_stimulus(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        idle();

        phase = "branch_over_load_use";
        apply_stimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        checks++;
        assert (fe1 === 16'd1 && sc1 === 16'd2) else begin
            errors++;
            $error("[TB] FAIL branch_flush_counts flush=%0d stall=%0d expected flush=1 stall=2", fe1, sc1);
        end

        phase = "saturation";
        apply_stimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            apply_stimulus(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
            idle();
        end
        checks++;
        assert (sc0 === 2'd3 && sc1 === 16'd5) else begin
            errors++;
            $error("[TB] FAIL stall_saturation cnt2=%0d cnt16=%0d expected cnt2=3 cnt16=5", sc0, sc1);
        end

        phase = "random";
        repeat (600) begin
            apply_stimulus(($urandom_range(0, 40) == 0), 1'($urandom),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 1'($urandom),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
